// File: rtl/store_buffer_pkg.sv
// Shared definitions for the posted-write store buffer: FSM encodings,
// hazard compare range and the FIFO entry layout.
package store_buffer_pkg;

  localparam int DEFAULT_DEPTH = 4;

  localparam int HAZ_MSB = 11;
  localparam int HAZ_LSB = 2;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE_LD = 3'd1;
  localparam logic [2:0] S_ISSUE_ST = 3'd2;
  localparam logic [2:0] S_WAIT_LD  = 3'd3;
  localparam logic [2:0] S_WAIT_ST  = 3'd4;
  localparam logic [2:0] S_LD_DONE  = 3'd5;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular store queue with registered empty flag and a parallel
// word-address match across all valid entries for load hazard detection.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  sb_entry_t              push_entry_i,
  input  logic                   pop_i,
  input  logic [HAZ_MSB:HAZ_LSB] match_field_i,
  output sb_entry_t              head_o,
  output logic [PTR_W:0]         count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   match_o
);

  sb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             empty_q;
  logic             do_push, do_pop;
  logic [DEPTH-1:0] valid;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & (count_q != '0);
  assign head_o  = entries_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    valid   = '0;
    match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
      if (valid[i] && (entries_q[i].addr[HAZ_MSB:HAZ_LSB] == match_field_i))
        match_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) entries_q[wr_ptr_q] <= push_entry_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the CPU memory stage and data memory:
// queues stores, lets non-conflicting loads bypass them, drains in background.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall,
  output logic        buf_empty
);

  logic [2:0]     state_q, state_d;
  logic           hit_wait_q, hit_wait_d;
  logic           wait_first_q;
  logic [31:0]    addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]     mask_q, mask_d;
  logic           memread_q, memwrite_q;

  sb_entry_t      push_entry, head;
  logic [PTR_W:0] fifo_count;
  logic           fifo_full, fifo_empty, fifo_match;
  logic           ld_req, ld_ok, wait_done, pop;

  assign push_entry = '{addr: cpu_addr, data: cpu_write_data, mask: cpu_sign_mask};

  sb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (cpu_memwrite),
    .push_entry_i  (push_entry),
    .pop_i         (pop),
    .match_field_i (cpu_addr[HAZ_MSB:HAZ_LSB]),
    .head_o        (head),
    .count_o       (fifo_count),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .match_o       (fifo_match)
  );

  // A load that once hit a queued word keeps waiting until the queue is empty.
  assign ld_req    = cpu_memread & ~cpu_memwrite;
  assign ld_ok     = ld_req & (hit_wait_q ? fifo_empty : ~fifo_match);
  assign wait_done = ~wait_first_q & ~mem_clk_stall;
  assign pop       = (state_q == S_WAIT_ST) & wait_done;

  assign cpu_stall = (cpu_memwrite & fifo_full) | (cpu_memread & (state_q != S_LD_DONE));

  assign cpu_read_data  = rdata_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_sign_mask  = mask_q;
  assign mem_memread    = memread_q;
  assign mem_memwrite   = memwrite_q;
  assign buf_empty      = fifo_empty;

  always_comb begin
    state_d    = state_q;
    hit_wait_d = hit_wait_q & ld_req;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    rdata_d    = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (ld_ok) begin
          state_d    = S_ISSUE_LD;
          hit_wait_d = 1'b0;
          addr_d     = cpu_addr;
          wdata_d    = '0;
          mask_d     = cpu_sign_mask;
        end else begin
          if (ld_req && fifo_match) hit_wait_d = 1'b1;
          if (fifo_count != '0) begin
            state_d = S_ISSUE_ST;
            addr_d  = head.addr;
            wdata_d = head.data;
            mask_d  = head.mask;
          end
        end
      end
      S_ISSUE_LD: state_d = S_WAIT_LD;
      S_ISSUE_ST: state_d = S_WAIT_ST;
      S_WAIT_LD: begin
        if (wait_done) begin
          state_d = S_LD_DONE;
          rdata_d = mem_read_data;
        end
      end
      S_WAIT_ST: if (wait_done) state_d = S_IDLE;
      S_LD_DONE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hit_wait_q   <= 1'b0;
      wait_first_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      rdata_q      <= '0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hit_wait_q   <= hit_wait_d;
      wait_first_q <= (state_q == S_ISSUE_LD) || (state_q == S_ISSUE_ST);
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      rdata_q      <= rdata_d;
      memread_q    <= (state_d == S_ISSUE_LD);
      memwrite_q   <= (state_d == S_ISSUE_ST);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer with a word-addressed
// memory model and a log of every request the memory sees.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_addr, cpu_write_data, cpu_read_data;
  logic        cpu_memwrite, cpu_memread, cpu_stall;
  logic [3:0]  cpu_sign_mask, mem_sign_mask;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread, mem_clk_stall, buf_empty;

  logic [31:0] memArr [0:1023];
  logic [32:0] evLog [$];
  logic        emptyAtRead;
  logic        memBusy;
  int          checks;
  int          errors;
  int          stallCycles;

  store_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_addr       (cpu_addr),
    .cpu_write_data (cpu_write_data),
    .cpu_memwrite   (cpu_memwrite),
    .cpu_memread    (cpu_memread),
    .cpu_sign_mask  (cpu_sign_mask),
    .cpu_read_data  (cpu_read_data),
    .cpu_stall      (cpu_stall),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_sign_mask  (mem_sign_mask),
    .mem_read_data  (mem_read_data),
    .mem_clk_stall  (mem_clk_stall),
    .buf_empty      (buf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_clk_stall = memBusy;
  assign mem_read_data = memArr[mem_addr[11:2]];

  // Memory model: records each request (bit 32 = write) and applies stores.
  always @(posedge clk) begin
    if (mem_memwrite) begin
      memArr[mem_addr[11:2]] = mem_write_data;
      evLog.push_back({1'b1, mem_addr});
    end
    if (mem_memread) begin
      evLog.push_back({1'b0, mem_addr});
      emptyAtRead = buf_empty;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic re, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] mask);
    cpu_memwrite   = we;
    cpu_memread    = re;
    cpu_addr       = addr;
    cpu_write_data = data;
    cpu_sign_mask  = mask;
  endtask

  task automatic waitEmpty(input string tag);
    int n = 0;
    while (!buf_empty && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(buf_empty), 32'd1);
  endtask

  // Counts cycles with cpu_stall high, starting with the current one.
  task automatic countStall(output int n);
    n = 0;
    #1;
    while (cpu_stall && n < 60) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    memBusy     = 1'b0;
    emptyAtRead = 1'b0;
    rst_n       = 1'b0;
    for (int i = 0; i < 1024; i++) memArr[i] = 32'h0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    checkOutput("rst_buf_empty", 32'(buf_empty), 32'd1);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_req", {30'b0, mem_memwrite, mem_memread}, 32'h0);
    checkOutput("rst_read_data", cpu_read_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single store into an empty buffer
    applyStimulus(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
    #1 checkOutput("st1_stall", 32'(cpu_stall), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("st1_not_empty", 32'(buf_empty), 32'd0);
    for (int n = 0; n < 20 && !mem_memwrite; n++) @(negedge clk);
    checkOutput("st1_memwrite", 32'(mem_memwrite), 32'd1);
    checkOutput("st1_addr", mem_addr, 32'h10);
    checkOutput("st1_data", mem_write_data, 32'hDEADBEEF);
    checkOutput("st1_mask", 32'(mem_sign_mask), 32'hF);
    @(negedge clk);
    checkOutput("st1_pulse_end", 32'(mem_memwrite), 32'd0);
    waitEmpty("st1_drained");
    checkOutput("st1_mem_word", memArr[4], 32'hDEADBEEF);

    // Load with idle engine: four stall cycles then data
    @(negedge clk);
    evLog.delete();
    memArr[8] = 32'h12345678;
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h0, 4'hF);
    countStall(stallCycles);
    checkOutput("ld_stall_cycles", 32'(stallCycles), 32'd4);
    checkOutput("ld_data", cpu_read_data, 32'h12345678);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("ld_req_count", 32'(evLog.size()), 32'd1);
    checkOutput("ld_req_addr", evLog[0][31:0], 32'h20);

    // Five stores with memory busy: fifth stalls until the first pop
    evLog.delete();
    memBusy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF);
      #1 checkOutput($sformatf("burst_stall%0d", i), 32'(cpu_stall), 32'd0);
      @(negedge clk);
    end
    applyStimulus(1'b1, 1'b0, 32'h110, 32'h1004, 4'hF);
    #1 checkOutput("burst_full_stall", 32'(cpu_stall), 32'd1);
    repeat (3) @(negedge clk);
    #1 checkOutput("burst_still_stall", 32'(cpu_stall), 32'd1);
    memBusy = 1'b0;
    checkOutput("burst_pop_cycle_stall", 32'(cpu_stall), 32'd1);
    @(negedge clk);
    #1 checkOutput("burst_unstall", 32'(cpu_stall), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitEmpty("burst_drained");
    checkOutput("burst_count", 32'(evLog.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("burst_order%0d", i), evLog[i][31:0], 32'h100 + 32'(4 * i));
    checkOutput("burst_last_data", memArr[32'h110 >> 2], 32'h1004);

    // Non-matching load bypasses a queued store
    @(negedge clk);
    evLog.delete();
    memArr[32'h48 >> 2] = 32'hCAFEF00D;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h40, 4'hF);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h44, 32'h44, 4'hF);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'h48, 32'h0, 4'hF);
    countStall(stallCycles);
    checkOutput("bypass_data", cpu_read_data, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitEmpty("bypass_drained");
    checkOutput("bypass_ev0", {31'b0, evLog[0][32]} ^ evLog[0][31:0], 32'h41);
    checkOutput("bypass_ev1_read", 32'(evLog[1][32]), 32'd0);
    checkOutput("bypass_ev1_addr", evLog[1][31:0], 32'h48);
    checkOutput("bypass_ev2_addr", evLog[2][31:0], 32'h44);

    // Matching load waits for the buffer to empty
    @(negedge clk);
    evLog.delete();
    applyStimulus(1'b1, 1'b0, 32'h50, 32'hA5, 4'hF);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'h53, 32'h0, 4'hF);
    countStall(stallCycles);
    checkOutput("hazard_data", cpu_read_data, 32'hA5);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("hazard_ev0_addr", evLog[0][31:0], 32'h50);
    checkOutput("hazard_ev1_read", 32'(evLog[1][32]), 32'd0);
    checkOutput("hazard_ev1_addr", evLog[1][31:0], 32'h53);
    checkOutput("hazard_empty_at_read", 32'(emptyAtRead), 32'd1);

    // Reset during a stalled drain with three entries queued
    evLog.delete();
    memBusy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h200 + 32'(4 * i), 32'h2000 + 32'(i), 4'hF);
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (4) @(negedge clk);
    checkOutput("rst2_pre_addr", mem_addr, 32'h200);
    checkOutput("rst2_pre_empty", 32'(buf_empty), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst2_addr", mem_addr, 32'h0);
    checkOutput("rst2_wdata", mem_write_data, 32'h0);
    checkOutput("rst2_mask", 32'(mem_sign_mask), 32'h0);
    checkOutput("rst2_req", {30'b0, mem_memwrite, mem_memread}, 32'h0);
    checkOutput("rst2_read_data", cpu_read_data, 32'h0);
    checkOutput("rst2_empty", 32'(buf_empty), 32'd1);
    @(negedge clk);
    rst_n   = 1'b1;
    memBusy = 1'b0;
    evLog.delete();
    repeat (10) @(negedge clk);
    checkOutput("rst2_no_requests", 32'(evLog.size()), 32'd0);
    checkOutput("rst2_still_empty", 32'(buf_empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
